nx_ram_1rw_ctrl: RTL and testbench

- Initiator-side controller for a single-port 1rw RAM: one cycle per access (cs/we/add/din/bwe), read data on ram_dout the cycle after issue.
- Fills the whole array with INIT_VAL after reset and on software request.
- Then serves a valid/ready request port and returns read data through a 2-entry response FIFO with backpressure.
- Sits between a datapath client and a RAM instance of the same WIDTH/DEPTH.

---
 rtl/nx_ram_1rw_ctrl.sv | 151 +++++++++++++++
 tb/tb_nx_ram_1rw_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_ram_1rw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nx_ram_1rw_ctrl : fills a 1rw RAM after reset / sw_init, then serves  |
// | valid/ready requests with a 2-entry read response FIFO.               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module nx_ram_1rw_ctrl #(
    parameter int               WIDTH    = 96,
    parameter int               DEPTH    = 512,
    parameter int               AW       = 9,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_init,
    output logic             init_done,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [WIDTH-1:0] req_bwe,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             ram_cs,
    output logic             ram_we,
    output logic [AW-1:0]    ram_add,
    output logic [WIDTH-1:0] ram_din,
    output logic [WIDTH-1:0] ram_bwe,
    input  logic [WIDTH-1:0] ram_dout
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    cnt_q;
    logic             init_done_q;
    logic             rd_pend_q;
    logic [WIDTH-1:0] fifo_q [2];
    logic [1:0]       fifo_cnt_q;
    logic [1:0]       fifo_cnt_d;
    logic             wr_ptr_q;
    logic             rd_ptr_q;

    logic             push;
    logic             pop;
    logic             accept;
    logic [1:0]       credit;

    // Credits count FIFO entries plus the read still in flight in the RAM.
    assign credit    = fifo_cnt_q + {1'b0, rd_pend_q};
    assign push      = rd_pend_q;
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_valid = (fifo_cnt_q != 2'd0);
    assign rsp_rdata = fifo_q[rd_ptr_q];
    assign init_done = init_done_q;
    assign req_ready = (state_q == ST_READY) && (pop ? (credit <= 2'd2) : (credit <= 2'd1));
    assign accept    = req_valid & req_ready;

    always_comb begin
        ram_cs  = 1'b0;
        ram_we  = 1'b0;
        ram_add = '0;
        ram_din = '0;
        ram_bwe = '0;
        if (state_q == ST_INIT) begin
            ram_cs  = 1'b1;
            ram_we  = 1'b1;
            ram_add = cnt_q;
            ram_din = INIT_VAL;
            ram_bwe = '1;
        end else if (accept) begin
            ram_cs  = 1'b1;
            ram_we  = req_we;
            ram_add = req_addr;
            ram_din = req_wdata;
            ram_bwe = req_bwe;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q     <= ST_READY;
                        cnt_q       <= '0;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                ST_READY: begin
                    if (sw_init) begin
                        state_q     <= ST_DRAIN;
                        init_done_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // The last accepted read must land in the FIFO before init overwrites the array.
                    if (!rd_pend_q) begin
                        state_q <= ST_INIT;
                    end
                end
                default: begin
                    state_q     <= ST_INIT;
                    cnt_q       <= '0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            fifo_cnt_q <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            rd_pend_q <= accept & ~req_we;
            if (push) begin
                fifo_q[wr_ptr_q] <= ram_dout;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nx_ram_1rw_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nx_ram_1rw_ctrl : bench for nx_ram_1rw_ctrl with a behavioural RAM |
// | and a queue-based response model. Rev 1.0                             |
// +----------------------------------------------------------------------+
module tb_nx_ram_1rw_ctrl;

    localparam int               WIDTH    = 96;
    localparam int               DEPTH    = 512;
    localparam int               AW       = 9;
    localparam logic [WIDTH-1:0] INIT_VAL = '0;
    localparam logic [WIDTH-1:0] ONES     = '1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             sw_init   = 1'b0;
    logic             init_done;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we    = 1'b0;
    logic [AW-1:0]    req_addr  = '0;
    logic [WIDTH-1:0] req_wdata = '0;
    logic [WIDTH-1:0] req_bwe   = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_rdata;
    logic             ram_cs;
    logic             ram_we;
    logic [AW-1:0]    ram_add;
    logic [WIDTH-1:0] ram_din;
    logic [WIDTH-1:0] ram_bwe;
    logic [WIDTH-1:0] ram_dout;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] ram_mem [DEPTH];
    logic [WIDTH-1:0] exp_mem [DEPTH];
    logic [WIDTH-1:0] exp_q [$];

    always #5 clk = ~clk;

    nx_ram_1rw_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .INIT_VAL(INIT_VAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_init(sw_init), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_bwe(req_bwe),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_add(ram_add), .ram_din(ram_din),
        .ram_bwe(ram_bwe), .ram_dout(ram_dout)
    );

    // Single-port RAM: bit-masked write, registered read.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram_mem[ram_add] <= (ram_mem[ram_add] & ~ram_bwe) | (ram_din & ram_bwe);
            else        ram_dout <= ram_mem[ram_add];
        end
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: array contents plus in-order queue of outstanding read results.
    logic mon_pop;
    int   mon_out;
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            mon_pop = rsp_valid && rsp_ready;
            mon_out = exp_q.size();
            if (mon_pop) begin
                if (mon_out == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %h with no read outstanding", rsp_rdata);
                end else begin
                    chk("rsp_data", rsp_rdata, exp_q.pop_front());
                end
            end
            if (init_done) chk1("req_ready_credit", req_ready, (mon_out - (mon_pop ? 1 : 0)) < 2);
            else           chk1("req_ready_down", req_ready, 1'b0);
            if (req_valid && req_ready) begin
                chk1("ram_issue", ram_cs && (ram_we == req_we) && (ram_add == req_addr) &&
                                  (ram_din == req_wdata) && (ram_bwe == req_bwe), 1'b1);
                if (req_we) exp_mem[req_addr] = (exp_mem[req_addr] & ~req_bwe) | (req_wdata & req_bwe);
                else        exp_q.push_back(exp_mem[req_addr]);
            end else if (init_done) begin
                chk1("ram_idle", ram_cs, 1'b0);
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        sw_init   = 1'b0;
        #2;
    endtask

    // Presents a request and returns at the sample point of the accepting cycle.
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] b);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_bwe = b; sw_init = 1'b0;
        #2;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: addr %0d not accepted after %0d cycles", a, n);
        end
    endtask

    task automatic wait_rsp(input string name, input logic [WIDTH-1:0] exp, output int lat);
        lat = 0;
        do begin
            idle();
            lat++;
        end while (!rsp_valid && lat < 20);
        chk1({name, "_valid"}, rsp_valid, 1'b1);
        chk({name, "_data"}, rsp_rdata, exp);
    endtask

    // Follows an init sweep; stop_at>0 returns at the sample where address stop_at is driven.
    task automatic init_phase(input int stop_at, input string name, input bit release_rst);
        int n;
        int bad;
        foreach (exp_mem[i]) exp_mem[i] = INIT_VAL;
        n   = 0;
        bad = 0;
        for (int cyc = 0; cyc < DEPTH + 20; cyc++) begin
            @(negedge clk);
            if (release_rst) rst_n = 1'b1;
            sw_init = (cyc == 50);
            #2;
            if (stop_at > 0 && n == stop_at) return;
            if (init_done) break;
            if (ram_cs) begin
                if (ram_we && ram_add == AW'(n) && ram_bwe == ONES && ram_din == INIT_VAL) n++;
                else bad++;
            end else if (n != 0) begin
                bad++;
            end
        end
        sw_init = 1'b0;
        chk1({name, "_done"}, init_done, 1'b1);
        checks++;
        if (n != DEPTH || bad != 0) begin
            errors++;
            $display("FAIL %s_writes: got %0d ordered writes (%0d bad) expected %0d", name, n, bad, DEPTH);
        end
    endtask

    typedef struct {
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
        logic [WIDTH-1:0] bwe;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t             vecs [8];
    logic [WIDTH-1:0] a5, c3, d8, e8, d9, v1, v2, v3;
    logic [AW-1:0]    b2b_addr [10];
    int               lat;
    bit               hold;
    int               n_wait;

    initial begin
        a5 = {12{8'hA5}};
        c3 = {12{8'h3C}};
        d8 = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
        e8 = 96'h0123_4567_89AB_0000_0000_0000;
        d9 = 96'hDEAD_BEEF_0000_1111_2222_3333;
        v1 = {3{32'h1111_0001}};
        v2 = {3{32'h2222_0002}};
        v3 = {3{32'h3333_0003}};
        vecs[0] = '{1'b1, AW'(7), a5, ONES, '0};
        vecs[1] = '{1'b1, AW'(7), c3, 96'hFF, '0};
        vecs[2] = '{1'b0, AW'(7), '0, '0, {{11{8'hA5}}, 8'h3C}};
        vecs[3] = '{1'b1, AW'(8), d8, 96'hFFFF_FFFF_FFFF_0000_0000_0000, '0};
        vecs[4] = '{1'b0, AW'(8), '0, '0, e8};
        vecs[5] = '{1'b1, AW'(9), d9, ONES, '0};
        vecs[6] = '{1'b0, AW'(9), '0, '0, d9};
        vecs[7] = '{1'b0, AW'(5), '0, '0, INIT_VAL};
        b2b_addr = '{AW'(1), AW'(2), AW'(3), AW'(7), AW'(8), AW'(9), AW'(5), AW'(1), AW'(2), AW'(3)};

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk1("rst_init_done", init_done, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, '0);

        rsp_ready = 1'b1;
        init_phase(0, "init_from_reset", 1'b1);

        send(1'b0, AW'(5), '0, '0);
        wait_rsp("rd5", INIT_VAL, lat);
        chk_int("rd5_latency", lat, 2);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].bwe);
            if (!vecs[i].we) wait_rsp($sformatf("vec%0d", i), vecs[i].exp, lat);
        end
        idle();

        // Backpressure: only two reads fit while responses are stalled
        send(1'b1, AW'(1), v1, ONES);
        send(1'b1, AW'(2), v2, ONES);
        send(1'b1, AW'(3), v3, ONES);
        idle();
        rsp_ready = 1'b0;
        @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(1); #2;
        chk1("bp_acc1", req_ready, 1'b1);
        @(negedge clk); req_addr = AW'(2); #2;
        chk1("bp_acc2", req_ready, 1'b1);
        @(negedge clk); req_addr = AW'(3); #2;
        chk1("bp_stall_first", req_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            chk1("bp_stall", req_ready, 1'b0);
            chk1("bp_hold_valid", rsp_valid, 1'b1);
        end
        @(negedge clk); rsp_ready = 1'b1; #2;
        chk("bp_first_data", rsp_rdata, v1);
        chk1("bp_resume", req_ready, 1'b1);
        idle();
        chk("bp_second_data", rsp_rdata, v2);
        idle();
        chk("bp_third_data", rsp_rdata, v3);
        idle();

        // Ten back-to-back reads, no bubbles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = b2b_addr[i]; #2;
            chk1("b2b_ready", req_ready, 1'b1);
            if (i >= 2) chk1("b2b_rsp_valid", rsp_valid, 1'b1);
        end
        idle(); chk1("b2b_tail9", rsp_valid, 1'b1);
        idle(); chk1("b2b_tail10", rsp_valid, 1'b1);
        idle(); chk1("b2b_empty", rsp_valid, 1'b0);

        // sw_init right after a read: data still delivered, held request survives re-init
        send(1'b0, AW'(8), '0, '0);
        @(negedge clk); req_valid = 1'b0; sw_init = 1'b1; #2;
        @(negedge clk); sw_init = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(3); #2;
        chk1("drain_init_done", init_done, 1'b0);
        chk1("drain_req_ready", req_ready, 1'b0);
        chk1("drain_rsp_valid", rsp_valid, 1'b1);
        chk("drain_rsp_data", rsp_rdata, e8);
        init_phase(0, "init_after_sw", 1'b0);
        chk1("held_accept", req_ready, 1'b1);
        wait_rsp("held_rd3", INIT_VAL, lat);
        send(1'b0, AW'(8), '0, '0);
        wait_rsp("reinit_rd8", INIT_VAL, lat);

        // Async reset in the middle of an init sweep while a response is parked
        send(1'b1, AW'(9), d9, ONES);
        rsp_ready = 1'b0;
        send(1'b0, AW'(9), '0, '0);
        @(negedge clk); req_valid = 1'b0; sw_init = 1'b1; #2;
        init_phase(200, "init_partial", 1'b0);
        chk1("partial_rsp_valid", rsp_valid, 1'b1);
        chk("partial_rsp_data", rsp_rdata, d9);
        chk("partial_addr", {{(WIDTH-AW){1'b0}}, ram_add}, 96'd200);
        rst_n = 1'b0;
        #1;
        chk1("midrst_init_done", init_done, 1'b0);
        chk1("midrst_req_ready", req_ready, 1'b0);
        chk1("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_rsp_rdata", rsp_rdata, '0);
        chk("midrst_addr", {{(WIDTH-AW){1'b0}}, ram_add}, '0);
        repeat (2) @(negedge clk);
        rsp_ready = 1'b1;
        init_phase(0, "init_after_rst", 1'b1);

        // Randomized traffic against the model
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                req_valid = ($urandom_range(0, 9) < 7);
                req_we    = $urandom_range(0, 1) != 0;
                req_addr  = AW'($urandom_range(0, 15));
                req_wdata = {$urandom(), $urandom(), $urandom()};
                req_bwe   = {$urandom(), $urandom(), $urandom()};
            end
            #2;
            hold = req_valid && !req_ready;
        end
        @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
        n_wait = 0;
        while (exp_q.size() != 0 && n_wait < 20) begin
            @(negedge clk); #2;
            n_wait++;
        end
        chk_int("drain_outstanding", exp_q.size(), 0);
        idle();
        chk1("final_rsp_valid", rsp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
